stack_exec_unit: RTL

//  Instruction sequencer directly upstream of storage_stack: owns its push/pop/data_in, reads its top.

---
 rtl/stack_pkg.sv | 58 +++++
 rtl/stack_alu.sv | 26 ++
 rtl/stack_exec_unit.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared widths, opcode/state encodings and opcode classification helpers
// for the stack execution unit.
package stack_pkg;

  localparam int unsigned OP_SIZE         = 32;
  localparam int unsigned STACK_DEPTH     = 1024;
  localparam int unsigned STACK_ADDR_SIZE = 10;
  // Depth must represent 0..STACK_DEPTH inclusive.
  localparam int unsigned DEPTH_W         = STACK_ADDR_SIZE + 1;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_PUSH = 4'h1,
    OP_POP  = 4'h2,
    OP_DUP  = 4'h3,
    OP_OUT  = 4'h4,
    OP_ADD  = 4'h5,
    OP_SUB  = 4'h6,
    OP_AND  = 4'h7,
    OP_OR   = 4'h8,
    OP_XOR  = 4'h9,
    OP_SWAP = 4'hA
  } op_e;

  typedef logic [2:0] state_e;
  localparam state_e ST_IDLE  = 3'd0;
  localparam state_e ST_POPB  = 3'd1;
  localparam state_e ST_WB    = 3'd2;
  localparam state_e ST_PUSHA = 3'd3;
  localparam state_e ST_PUSHB = 3'd4;

  // Minimum stack depth an opcode needs before it may start.
  function automatic logic [1:0] op_need(input logic [3:0] op);
    logic [1:0] n;
    case (op)
      OP_POP, OP_DUP, OP_OUT:                    n = 2'd1;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SWAP:                                   n = 2'd2;
      default:                                   n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic op_legal(input logic [3:0] op);
    return (op <= 4'hA);
  endfunction

  // Opcodes whose net effect is one extra entry (overflow candidates).
  function automatic logic op_grows(input logic [3:0] op);
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

  // Opcodes that pop two operands and continue through POPB.
  function automatic logic op_two_pop(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SWAP);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational two-operand ALU; a_i is the deeper operand, b_i the former top.
module stack_alu
  import stack_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  op_e          op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] result_o
);

  // Result selection; all arithmetic wraps modulo 2^W.
  always_comb begin
    result_o = '0;
    case (op_i)
      OP_ADD:  result_o = a_i + b_i;
      OP_SUB:  result_o = a_i - b_i;
      OP_AND:  result_o = a_i & b_i;
      OP_OR:   result_o = a_i | b_i;
      OP_XOR:  result_o = a_i ^ b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/stack_exec_unit.sv
// Instruction sequencer in front of storage_stack: expands each accepted
// instruction into single-edge push/pop operations, tracks logical depth,
// evaluates ALU ops and emits OUT values.
module stack_exec_unit #(
  parameter int unsigned OP_SIZE     = stack_pkg::OP_SIZE,
  parameter int unsigned STACK_DEPTH = stack_pkg::STACK_DEPTH
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        instr_valid,
  output logic                        instr_ready,
  input  logic [3:0]                  instr_op,
  input  logic [OP_SIZE-1:0]          instr_imm,
  output logic                        stk_push,
  output logic                        stk_pop,
  output logic [OP_SIZE-1:0]          stk_data_in,
  input  logic [OP_SIZE-1:0]          stk_top,
  output logic                        out_valid,
  output logic [OP_SIZE-1:0]          out_data,
  output logic [stack_pkg::DEPTH_W-1:0] depth,
  output logic                        error
);
  import stack_pkg::*;

  state_e               state_q, state_d;
  op_e                  op_q, op_d;
  logic [DEPTH_W-1:0]   depth_q, depth_d;
  logic                 error_q, error_d;
  logic                 out_valid_q, out_valid_d;
  logic [OP_SIZE-1:0]   out_data_q, out_data_d;
  logic [OP_SIZE-1:0]   opa_q, opa_d;
  logic [OP_SIZE-1:0]   opb_q, opb_d;
  logic [OP_SIZE-1:0]   alu_res;
  logic                 ready_c;
  logic                 accept_c;
  logic                 bad_c;
  logic                 push_c;
  logic                 pop_c;
  logic [OP_SIZE-1:0]   data_c;

  assign ready_c  = (state_q == ST_IDLE) && !error_q;
  assign accept_c = instr_valid && ready_c;

  // Legality is decided once at accept from the opcode's net depth effect.
  assign bad_c = !op_legal(instr_op)
              || (DEPTH_W'(op_need(instr_op)) > depth_q)
              || (op_grows(instr_op) && (depth_q == DEPTH_W'(STACK_DEPTH)));

  stack_alu #(.W(OP_SIZE)) u_alu (
    .op_i     (op_q),
    .a_i      (opb_q),
    .b_i      (opa_q),
    .result_o (alu_res)
  );

  // Next-state, stack-op and depth logic.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    depth_d     = depth_q;
    error_d     = error_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    opa_d       = opa_q;
    opb_d       = opb_q;
    push_c      = 1'b0;
    pop_c       = 1'b0;
    data_c      = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (bad_c) begin
            error_d = 1'b1;
          end else begin
            case (instr_op)
              OP_PUSH: begin
                push_c = 1'b1;
                data_c = instr_imm;
              end
              OP_DUP: begin
                push_c = 1'b1;
                data_c = stk_top;
              end
              OP_POP: pop_c = 1'b1;
              OP_OUT: begin
                pop_c       = 1'b1;
                out_valid_d = 1'b1;
                out_data_d  = stk_top;
              end
              default: begin
                if (op_two_pop(instr_op)) begin
                  pop_c   = 1'b1;
                  opa_d   = stk_top;
                  op_d    = op_e'(instr_op);
                  state_d = ST_POPB;
                end
              end
            endcase
          end
        end
      end
      ST_POPB: begin
        pop_c   = 1'b1;
        opb_d   = stk_top;
        state_d = (op_q == OP_SWAP) ? ST_PUSHA : ST_WB;
      end
      ST_WB: begin
        push_c  = 1'b1;
        data_c  = alu_res;
        state_d = ST_IDLE;
      end
      ST_PUSHA: begin
        push_c  = 1'b1;
        data_c  = opa_q;
        state_d = ST_PUSHB;
      end
      ST_PUSHB: begin
        push_c  = 1'b1;
        data_c  = opb_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push_c) begin
      depth_d = depth_q + DEPTH_W'(1);
    end else if (pop_c) begin
      depth_d = depth_q - DEPTH_W'(1);
    end
  end

  // State and datapath registers; reset marks the stack logically empty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_NOP;
      depth_q     <= '0;
      error_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      depth_q     <= depth_d;
      error_q     <= error_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
    end
  end

  assign instr_ready = ready_c;
  assign stk_push    = push_c;
  assign stk_pop     = pop_c;
  assign stk_data_in = data_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign depth       = depth_q;
  assign error       = error_q;

endmodule
